fractcam_lookup: RTL and testbench

FRACTCAM_LOOKUP -- requirements
Module: fractcam_lookup

---
 rtl/fractcam_lookup.sv | 151 +++++++++++++++
 tb/tb_fractcam_lookup.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fractcam_lookup.sv
// Lookup front-end for an external TCAM. It registers the search key, tracks tags
// through the match latency, priority-encodes match_line and queues results in a credit-limited FIFO.
module fractcam_lookup #(
    parameter int unsigned KEY_WIDTH     = 10,
    parameter int unsigned TCAM_DEPTH    = 16,
    parameter int unsigned TAG_WIDTH     = 8,
    parameter int unsigned MATCH_LATENCY = 0,
    parameter int unsigned FIFO_DEPTH    = 4,
    localparam int unsigned IDX_W        = $clog2(TCAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_WIDTH-1:0]  req_key,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  tcam_busy,
    output logic [KEY_WIDTH-1:0]  search_key,
    input  logic [TCAM_DEPTH-1:0] match_line,
    output logic                  rsp_hit,
    output logic                  rsp_multi,
    output logic [IDX_W-1:0]      rsp_index,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  rsp_err,
    output logic                  rsp_valid,
    input  logic                  rsp_ready
);
    localparam int unsigned ML    = MATCH_LATENCY;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                 hit;
        logic                 multi;
        logic                 err;
        logic [IDX_W-1:0]     idx;
        logic [TAG_WIDTH-1:0] tag;
    } result_t;

    logic                 rst_q;
    logic [KEY_WIDTH-1:0] search_key_q;
    logic [ML:0]          stg_valid_q;
    logic [ML:0]          stg_err_q;
    logic [TAG_WIDTH-1:0] stg_tag_q [ML+1];
    result_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;

    logic       accept, fifo_wr, fifo_rd, credit_ok;
    logic       enc_hit, enc_multi;
    logic [IDX_W-1:0] enc_idx;
    result_t    wr_entry, head;

    // Credits cover both queued and in-flight results so the FIFO can never overflow.
    assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH);
    assign req_ready = !rst && !rst_q && !tcam_busy && credit_ok;
    assign accept    = req_valid && req_ready;
    assign fifo_wr   = stg_valid_q[ML];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign fifo_rd   = rsp_valid && rsp_ready;

    // Lowest set bit wins; a second set bit anywhere flags multi.
    always_comb begin
        enc_hit   = 1'b0;
        enc_multi = 1'b0;
        enc_idx   = '0;
        for (int i = TCAM_DEPTH - 1; i >= 0; i--) begin
            if (match_line[i]) begin
                enc_multi = enc_multi | enc_hit;
                enc_hit   = 1'b1;
                enc_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        wr_entry.hit   = enc_hit;
        wr_entry.multi = enc_multi;
        wr_entry.err   = stg_err_q[ML] | tcam_busy;
        wr_entry.idx   = enc_idx;
        wr_entry.tag   = stg_tag_q[ML];
    end

    always_comb begin
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        if (accept && !fifo_wr)      inflight_d = inflight_q + CNT_W'(1);
        else if (!accept && fifo_wr) inflight_d = inflight_q - CNT_W'(1);
        if (fifo_wr && !fifo_rd)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        else if (!fifo_wr && fifo_rd) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end

    // Key register and tag/valid/err shift pipeline aligned with the TCAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q        <= 1'b1;
            search_key_q <= '0;
            stg_valid_q  <= '0;
            stg_err_q    <= '0;
            for (int k = 0; k <= ML; k++) stg_tag_q[k] <= '0;
        end else begin
            rst_q        <= 1'b0;
            if (accept) begin
                search_key_q <= req_key;
                stg_tag_q[0] <= req_tag;
            end
            stg_valid_q[0] <= accept;
            stg_err_q[0]   <= 1'b0;
            for (int k = 1; k <= ML; k++) begin
                stg_valid_q[k] <= stg_valid_q[k-1];
                stg_err_q[k]   <= stg_err_q[k-1] | tcam_busy;
                stg_tag_q[k]   <= stg_tag_q[k-1];
            end
        end
    end

    // Result FIFO and credit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
        end else begin
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_wr && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign search_key = search_key_q;
    assign rsp_hit    = head.hit;
    assign rsp_multi  = head.multi;
    assign rsp_err    = head.err;
    assign rsp_index  = head.idx;
    assign rsp_tag    = head.tag;

endmodule

// File: tb/tb_fractcam_lookup.sv
// Scoreboard bench for fractcam_lookup: a key-indexed match table stands in for the TCAM,
// stimulus pushes hand-computed results, a negedge monitor pops and compares on each handshake.
module tb_fractcam_lookup;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  req_key;
    logic [7:0]  req_tag;
    logic        req_valid;
    logic        req_ready;
    logic        tcam_busy;
    logic [9:0]  search_key;
    logic [15:0] match_line;
    logic        rsp_hit, rsp_multi, rsp_err, rsp_valid, rsp_ready;
    logic [3:0]  rsp_index;
    logic [7:0]  rsp_tag;

    fractcam_lookup dut (
        .clk(clk), .rst(rst),
        .req_key(req_key), .req_tag(req_tag), .req_valid(req_valid), .req_ready(req_ready),
        .tcam_busy(tcam_busy), .search_key(search_key), .match_line(match_line),
        .rsp_hit(rsp_hit), .rsp_multi(rsp_multi), .rsp_index(rsp_index), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] tag;
        logic       hit;
        logic       multi;
        logic       err;
        logic [3:0] idx;
    } exp_t;

    // key, tag, match_line, expected hit / index / multi
    logic [9:0]  vk [12] = '{10'h155, 10'h0AA, 10'h3FF, 10'h001, 10'h200, 10'h123,
                             10'h0F0, 10'h00F, 10'h2A5, 10'h15A, 10'h321, 10'h0C3};
    logic [7:0]  vt [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                             8'h77, 8'h88, 8'h99, 8'hA0, 8'hB1, 8'hC2};
    logic [15:0] vm [12] = '{16'h0120, 16'h0000, 16'h8000, 16'h0001, 16'hFFFF, 16'h0410,
                             16'h4000, 16'h0300, 16'h0002, 16'h0C00, 16'h0080, 16'h1010};
    logic        vh [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  vi [12] = '{4'd5, 4'd0, 4'd15, 4'd0, 4'd0, 4'd4, 4'd14, 4'd8, 4'd1, 4'd10, 4'd7, 4'd4};
    logic        vmu[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    exp_t exp_q [$];
    int   checks = 0;
    int   fails  = 0;

    // TCAM stand-in: match_line follows the registered key.
    always_comb begin
        match_line = '0;
        for (int i = 0; i < 12; i++)
            if (search_key == vk[i]) match_line = vm[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: got tag %0h expected none at %0t", rsp_tag, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_tag",   32'(rsp_tag),   32'(e.tag));
                chk("rsp_hit",   32'(rsp_hit),   32'(e.hit));
                chk("rsp_multi", 32'(rsp_multi), 32'(e.multi));
                chk("rsp_index", 32'(rsp_index), 32'(e.idx));
                chk("rsp_err",   32'(rsp_err),   32'(e.err));
            end
        end
    end

    task automatic push(input int v, input bit err);
        exp_q.push_back('{tag: vt[v], hit: vh[v], multi: vmu[v], err: err, idx: vi[v]});
    endtask

    // Offer vector v until accepted; leaves req_valid high, returns at posedge+1.
    task automatic send(input int v, input bit err, output int waited);
        req_key   = vk[v];
        req_tag   = vt[v];
        req_valid = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (!req_ready) begin
            fails++;
            $display("FAIL send_timeout: got req_ready 0 expected 1 for vector %0d", v);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            push(v, err);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, tot, acc, seen;
        logic rdy;
        rst = 1'b1; req_key = '0; req_tag = '0; req_valid = 1'b0;
        tcam_busy = 1'b0; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_search_key", 32'(search_key), 32'd0);
        chk("rst_rsp_tag",    32'(rsp_tag),    32'd0);
        chk("rst_rsp_hit",    32'(rsp_hit),    32'd0);
        chk("rst_rsp_index",  32'(rsp_index),  32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst_fall", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_rst_settle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // First lookup with latency checks, then the remaining single vectors.
        send(0, 1'b0, w);
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("lat_t1_search_key", 32'(search_key), 32'h155);
        @(negedge clk);
        chk("lat_t2_rsp_valid", 32'(rsp_valid), 32'd1);
        drain("drain_first");
        @(posedge clk); #1;
        for (int v = 1; v < 8; v++) begin
            send(v, 1'b0, w);
            req_valid = 1'b0;
            drain("drain_single");
            @(posedge clk); #1;
        end

        // Backpressure: six offered, four credits.
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            req_key = vk[acc]; req_tag = vt[acc]; req_valid = 1'b1;
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin
                push(acc, 1'b0);
                acc++;
            end
            #1;
        end
        req_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd4);
        @(negedge clk);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_held_tag", 32'(rsp_tag), 32'h11);
        @(posedge clk); #1 rsp_ready = 1'b1;
        send(4, 1'b0, w);
        send(5, 1'b0, w);
        req_valid = 1'b0;
        drain("drain_bp");
        @(posedge clk); #1;

        // Busy in the cycle after accept flags the result and blocks requests.
        send(6, 1'b1, w);
        req_valid = 1'b0;
        tcam_busy = 1'b1;
        @(negedge clk);
        chk("busy_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1 tcam_busy = 1'b0;
        @(negedge clk);
        chk("busy_ready_back", 32'(req_ready), 32'd1);
        drain("drain_busy");
        @(posedge clk); #1;

        // Back-to-back stream.
        tot = 0;
        for (int v = 0; v < 12; v++) begin
            send(v, 1'b0, w);
            tot += w;
        end
        req_valid = 1'b0;
        chk("b2b_stall_cycles", 32'(tot), 32'd0);
        drain("drain_b2b");
        @(posedge clk); #1;

        // Reset with results queued and in flight.
        rsp_ready = 1'b0;
        for (int v = 8; v < 12; v++) send(v, 1'b0, w);
        req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_rsp_tag",   32'(rsp_tag),   32'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        send(10, 1'b0, w);
        req_valid = 1'b0;
        drain("drain_post_rst");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
